core_fetch: RTL

- Instruction fetch unit: supplies 32-bit instruction words and their PCs to the exec-stage decoder over a valid/ready handshake.
- Issues one memory read at a time for the current PC and returns responses (or access faults) to exec.
- Takes control-flow redirects (jump, branch taken, trap, mret/sret) from exec and flushes any fetch in flight.

---
 rtl/core_fetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/core_fetch.sv
// Instruction fetch unit: one outstanding word read at a time, presents
// instruction/PC/fault to exec, and restarts at redirect_pc on redirect.
module core_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req_valid,
    input  logic        fetch_req_ready,
    output logic [31:0] fetch_req_addr,
    input  logic        fetch_rsp_valid,
    input  logic [31:0] fetch_rsp_data,
    input  logic        fetch_rsp_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        S_START,
        S_REQ,
        S_WAIT,
        S_DISCARD,
        S_HOLD
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, r_instr_pc;
    logic        r_instr_fault;
    logic        w_capture;
    logic [31:0] w_redir_pc;

    assign w_redir_pc = {redirect_pc[31:2], 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        case (r_state)
            S_START: w_state_nxt = S_REQ;
            S_REQ: begin
                // An accepted request that coincides with a redirect still
                // produces a response, which S_DISCARD swallows.
                if (redirect) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = fetch_req_ready ? S_DISCARD : S_REQ;
                end else if (fetch_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = fetch_rsp_valid ? S_REQ : S_DISCARD;
                end else if (fetch_rsp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (redirect)
                    w_pc_nxt = w_redir_pc;
                if (fetch_rsp_valid)
                    w_state_nxt = S_REQ;
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_REQ;
                end else if (instr_ready) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_START;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_instr_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_capture) begin
                r_instr       <= fetch_rsp_err ? 32'h0 : fetch_rsp_data;
                r_instr_fault <= fetch_rsp_err;
                r_instr_pc    <= r_pc;
            end
        end
    end

    assign fetch_req_valid = (r_state == S_REQ);
    assign instr_valid     = (r_state == S_HOLD);
    assign fetch_req_addr  = r_pc;
    assign instr           = r_instr;
    assign instr_pc        = r_instr_pc;
    assign instr_fault     = r_instr_fault;

endmodule
